if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-low; sampled on the rising edge of clk_i.
REQ-004 stall_i  input  1  ID stage cannot accept; IF/ID outputs hold.
REQ-005 flush_i  input  1  branch/jump taken; squash IF/ID and the in-flight fetch, redirect.
REQ-006 redirect_pc_i  input  32  new fetch target, valid when flush_i=1.
REQ-007 imem_req_o  output  1  fetch request to instruction memory.
REQ-008 imem_addr_o  output  32  fetch address; bits [1:0] always 0.
REQ-009 imem_ack_i  input  1  memory returns data this cycle for the current request.
REQ-010 imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-011 pc_o  output  32  IF/ID register: PC of held instruction.
REQ-012 instruction_o  output  32  IF/ID register: held instruction word.
REQ-013 valid_o  output  1  IF/ID register holds a real instruction (0 = bubble).
REQ-014 busy_o  output  1  high in HOLD or DISCARD state.

Function
REQ-015 Internal state: fetch_pc (32 bit), skid buffer {pc, word} (64 bit), FSM with states RUN, HOLD, DISCARD.
REQ-016 imem_req_o = 1 in RUN and DISCARD, 0 in HOLD; imem_addr_o = fetch_pc in RUN, the abandoned address in DISCARD; req/addr stable until ack.
REQ-017 Priority each cycle: rst_i low > flush_i > stall_i > normal flow.
REQ-018 RUN, ack, no stall, no flush: IF/ID <= {fetch_pc, imem_rdata_i, valid=1}; fetch_pc += 4 next cycle; stay RUN; fetch-to-IF/ID latency = 1 cycle after ack.
REQ-019 RUN, no ack, no stall: valid_o <= 0 (bubble), pc_o/instruction_o unchanged; stay RUN.
REQ-020 RUN, stall, no ack: IF/ID holds; stay RUN, request stays asserted.
REQ-021 RUN, ack, stall: skid <= {fetch_pc, imem_rdata_i}; fetch_pc += 4; IF/ID holds; go HOLD.
REQ-022 HOLD, stall: all registers hold. HOLD, no stall: IF/ID <= {skid.pc, skid.word, valid=1}; go RUN.
REQ-023 flush in RUN with ack same cycle: returned word dropped; fetch_pc <= {redirect_pc_i[31:2],2'b00}; stay RUN.
REQ-024 flush in RUN without ack: fetch_pc <= redirect target; go DISCARD; held address remains the old one.
REQ-025 DISCARD: on ack, data dropped, go RUN (new target fetched next cycle); a further flush updates fetch_pc to the newest target and stays DISCARD unless acked.
REQ-026 flush in HOLD: skid contents discarded; fetch_pc <= redirect target; go RUN.
REQ-027 Any flush: valid_o <= 0, pc_o <= 0, instruction_o <= 0 on the same edge, regardless of stall_i.
REQ-028 fetch_pc increment is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-029 redirect_pc_i[1:0] ignored (forced 00).
REQ-030 No instruction is ever duplicated or lost: every acked non-flushed word reaches IF/ID exactly once, in fetch order.

Reset
REQ-031 rst_i low at a rising edge: state <= RUN, fetch_pc <= RESET_PC, skid <= 0, pc_o <= 0, instruction_o <= 0, valid_o <= 0.
REQ-032 imem_req_o = 0 combinationally while rst_i is low; reset mid-request abandons it, and the memory model shall tolerate a dropped request.
REQ-033 First request after reset release: imem_addr_o = RESET_PC on the first cycle with rst_i high.

Verification
REQ-034 Zero-wait memory, ack every cycle, no stall, words 0x11,0x22,0x33 -> valid_o=1 with (pc_o,instruction_o) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles.
REQ-035 Ack at PC 0x8 while stall_i=1 for 3 cycles -> busy_o=1, imem_req_o=0, IF/ID unchanged; stall drop -> IF/ID=(0x8,word), next request addr 0xC.
REQ-036 Flush with redirect 0x100 while request at 0x10 unacked, ack after 2 cycles -> word dropped, valid_o=0, next addr 0x100, no 0x10 instruction ever valid.
REQ-037 flush_i and stall_i together in HOLD -> valid_o=0, skid discarded, next addr = redirect target.
REQ-038 RESET_PC=32'hFFFF_FFFC, acks each cycle -> second fetch addr 0x0000_0000.
REQ-039 rst_i low for one cycle mid-DISCARD -> all outputs 0, state RUN, next addr RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, owns the
// IF/ID pipeline register and absorbs ID back-pressure with a one-entry skid buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        valid_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {RUN, HOLD, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] disc_pc_q, disc_pc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_word_q, skid_word_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_inc;
    logic [31:0] redir_pc;

    assign pc_inc   = fetch_pc_q + 32'd4;
    assign redir_pc = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_pc_d   = disc_pc_q;
        skid_pc_d   = skid_pc_q;
        skid_word_d = skid_word_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;

        if (flush_i) begin
            valid_d    = 1'b0;
            pc_d       = 32'h0;
            instr_d    = 32'h0;
            fetch_pc_d = redir_pc;
            unique case (state_q)
                RUN: begin
                    // The outstanding request must still complete; remember its address.
                    if (!imem_ack_i) begin
                        state_d   = DISCARD;
                        disc_pc_d = fetch_pc_q;
                    end
                end
                HOLD: begin
                    state_d     = RUN;
                    skid_pc_d   = 32'h0;
                    skid_word_d = 32'h0;
                end
                DISCARD: begin
                    if (imem_ack_i) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end else begin
            unique case (state_q)
                RUN: begin
                    if (imem_ack_i) begin
                        fetch_pc_d = pc_inc;
                        if (stall_i) begin
                            skid_pc_d   = fetch_pc_q;
                            skid_word_d = imem_rdata_i;
                            state_d     = HOLD;
                        end else begin
                            pc_d    = fetch_pc_q;
                            instr_d = imem_rdata_i;
                            valid_d = 1'b1;
                        end
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        pc_d    = skid_pc_q;
                        instr_d = skid_word_q;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) state_d = RUN;
                    if (!stall_i) valid_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            disc_pc_q   <= 32'h0;
            skid_pc_q   <= 32'h0;
            skid_word_q <= 32'h0;
            pc_q        <= 32'h0;
            instr_q     <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_pc_q   <= disc_pc_d;
            skid_pc_q   <= skid_pc_d;
            skid_word_q <= skid_word_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

    // Request drops immediately under reset so an in-flight fetch is abandoned.
    assign imem_req_o    = rst_i && (state_q != HOLD);
    assign imem_addr_o   = (state_q == DISCARD) ? disc_pc_q : fetch_pc_q;
    assign pc_o          = pc_q;
    assign instruction_o = instr_q;
    assign valid_o       = valid_q;
    assign busy_o        = (state_q != RUN);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table for the corner cases, then
// randomized traffic checked against an in-order instruction stream model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, ack;
    logic [31:0] redir, rdata;
    logic        req, valid, busy;
    logic [31:0] addr, pc, instr;

    logic        req2, valid2, busy2;
    logic [31:0] addr2, pc2, instr2;
    logic        ack2;
    logic [31:0] rdata2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redir), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_o(pc),
        .instruction_o(instr), .valid_o(valid), .busy_o(busy)
    );

    // Second instance exercises the address wrap from the top of memory.
    assign ack2   = req2;
    assign rdata2 = addr2 ^ 32'h5A5A_0000;

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(1'b0), .flush_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(ack2), .imem_rdata_i(rdata2), .pc_o(pc2),
        .instruction_o(instr2), .valid_o(valid2), .busy_o(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct packed {
        logic        rst, stall, flush, ack;
        logic [31:0] redir, rdata;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
    } vec_t;

    vec_t tbl [23];

    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_req, prev_ack;
        int          delivered;

        tbl[0]  = '{1,0,0,1, 32'h0,   32'h11,   1, 32'h0,   32'h11,  1, 32'h4,   0};
        tbl[1]  = '{1,0,0,1, 32'h0,   32'h22,   1, 32'h4,   32'h22,  1, 32'h8,   0};
        tbl[2]  = '{1,0,0,1, 32'h0,   32'h33,   1, 32'h8,   32'h33,  1, 32'hC,   0};
        tbl[3]  = '{0,0,0,0, 32'h0,   32'h0,    0, 32'h0,   32'h0,   0, 32'h0,   0};
        tbl[4]  = '{1,0,0,1, 32'h0,   32'hA0,   1, 32'h0,   32'hA0,  1, 32'h4,   0};
        tbl[5]  = '{1,0,0,1, 32'h0,   32'hA4,   1, 32'h4,   32'hA4,  1, 32'h8,   0};
        tbl[6]  = '{1,1,0,1, 32'h0,   32'hA8,   1, 32'h4,   32'hA4,  0, 32'h0,   1};
        tbl[7]  = '{1,1,0,0, 32'h0,   32'h0,    1, 32'h4,   32'hA4,  0, 32'h0,   1};
        tbl[8]  = '{1,1,0,0, 32'h0,   32'h0,    1, 32'h4,   32'hA4,  0, 32'h0,   1};
        tbl[9]  = '{1,0,0,0, 32'h0,   32'h0,    1, 32'h8,   32'hA8,  1, 32'hC,   0};
        tbl[10] = '{1,0,0,1, 32'h0,   32'hAC,   1, 32'hC,   32'hAC,  1, 32'h10,  0};
        tbl[11] = '{1,0,1,0, 32'h101, 32'h0,    0, 32'h0,   32'h0,   1, 32'h10,  1};
        tbl[12] = '{1,0,0,0, 32'h0,   32'h0,    0, 32'h0,   32'h0,   1, 32'h10,  1};
        tbl[13] = '{1,0,0,1, 32'h0,   32'hDEAD, 0, 32'h0,   32'h0,   1, 32'h100, 0};
        tbl[14] = '{1,0,0,1, 32'h0,   32'hB00,  1, 32'h100, 32'hB00, 1, 32'h104, 0};
        tbl[15] = '{1,1,0,1, 32'h0,   32'hB04,  1, 32'h100, 32'hB00, 0, 32'h0,   1};
        tbl[16] = '{1,1,1,0, 32'h202, 32'h0,    0, 32'h0,   32'h0,   1, 32'h200, 0};
        tbl[17] = '{1,0,0,1, 32'h0,   32'hC00,  1, 32'h200, 32'hC00, 1, 32'h204, 0};
        tbl[18] = '{1,0,1,0, 32'h300, 32'h0,    0, 32'h0,   32'h0,   1, 32'h204, 1};
        tbl[19] = '{0,0,0,0, 32'h0,   32'h0,    0, 32'h0,   32'h0,   0, 32'h0,   0};
        tbl[20] = '{1,0,0,0, 32'h0,   32'h0,    0, 32'h0,   32'h0,   1, 32'h0,   0};
        tbl[21] = '{1,0,0,1, 32'h0,   32'h5,    1, 32'h0,   32'h5,   1, 32'h4,   0};
        tbl[22] = '{1,0,0,0, 32'h0,   32'h0,    0, 32'h0,   32'h5,   1, 32'h4,   0};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0;
        redir = 32'h0; rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", {31'h0, req}, 32'h0);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'h0, req}, 32'h1);
        chk("first_addr", addr, 32'h0);
        chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);

        for (int i = 0; i < 23; i++) begin
            if (i != 0) @(negedge clk);
            rst_n = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
            ack = tbl[i].ack; redir = tbl[i].redir; rdata = tbl[i].rdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("v%0d_req", i), {31'h0, req}, {31'h0, tbl[i].e_req});
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].e_busy});
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
            if (i == 0) begin
                chk("wrap_second_addr", addr2, 32'h0);
                chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                chk("wrap_valid", {31'h0, valid2}, 32'h1);
            end
        end

        // Randomized phase: every word delivered to ID must follow the fetch stream.
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (req) chk("addr_align", {30'h0, addr[1:0]}, 32'h0);
            if (prev_req && !prev_ack) begin
                chk("req_held", {31'h0, req}, 32'h1);
                chk("addr_held", addr, prev_addr);
            end
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            redir = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h000F_FFFF);
            ack   = req && ($urandom_range(0, 9) < 6);
            rdata = ack ? word_of(addr) : $urandom;
            if (valid && !stall && !flush) begin
                chk("stream_pc", pc, exp_pc);
                chk("stream_instr", instr, word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (flush) exp_pc = {redir[31:2], 2'b00};
            prev_req = req; prev_ack = ack; prev_addr = addr;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (delivered < 200) begin
            failures++;
            $display("FAIL stream_progress: got %0d deliveries expected at least 200", delivered);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
